// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_pkg
// Brief  : Shared fetch-stage types, reset/halt vectors and a byte-swap helper.
// Rev    : 1.0
// ============================================================================
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_HOLD  = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR      = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] byteswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module : mips_instruction_fetch
// Brief  : Avalon-MM instruction fetch stage with stall, flush, halt and fault.
// Rev    : 1.0
// ============================================================================
module mips_instruction_fetch
  import mips_pkg::*;
#(
  parameter bit          BYTE_SWAP = 1'b0,
  parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_pc,
  output logic        pc_adv,
  output logic        active,
  output logic        fault
);

  fetch_state_t r_state;
  logic [31:0]  r_addr;
  logic         r_read;
  logic [3:0]   r_be;
  logic [31:0]  r_instr;
  logic         r_valid;
  logic [31:0]  r_ipc;
  logic         r_active;
  logic         r_fault;
  logic         r_discard;

  logic [31:0]  w_rdata;
  logic         w_done;
  logic         w_accept;
  logic         w_do_entry;
  fetch_state_t w_entry_state;

  generate
    if (BYTE_SWAP) begin : g_swap
      assign w_rdata = byteswap32(avm_readdata);
    end else begin : g_pass
      assign w_rdata = avm_readdata;
    end
  endgenerate

  assign w_done   = (r_state == ST_REQ) && r_read && !avm_waitrequest;
  assign w_accept = (r_state == ST_HOLD) && r_valid && instr_ready && !flush;

  // HOLD with nothing held is the slot where the (possibly advanced) pc is checked.
  assign w_do_entry = ((r_state == ST_IDLE) && start) ||
                      ((r_state == ST_HOLD) && !r_valid);

  always_comb begin
    w_entry_state = ST_REQ;
    if (pc == HALT_ADDR) begin
      w_entry_state = ST_HALT;
    end else if (pc[1:0] != 2'b00) begin
      w_entry_state = ST_FAULT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= 32'h0;
      r_read    <= 1'b0;
      r_be      <= 4'h0;
      r_instr   <= 32'h0;
      r_valid   <= 1'b0;
      r_ipc     <= 32'h0;
      r_active  <= 1'b0;
      r_fault   <= 1'b0;
      r_discard <= 1'b0;
    end else if (w_do_entry) begin
      r_state  <= w_entry_state;
      r_active <= (w_entry_state == ST_REQ);
      if (w_entry_state == ST_REQ) begin
        r_addr <= pc;
        r_ipc  <= pc;
        r_read <= 1'b1;
        r_be   <= 4'hF;
      end
      if (w_entry_state == ST_FAULT) begin
        r_fault <= 1'b1;
      end
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_done) begin
            r_read    <= 1'b0;
            r_be      <= 4'h0;
            r_discard <= 1'b0;
            r_state   <= ST_HOLD;
            // A flush seen at any point during the transfer drops the word.
            if (!(r_discard || flush)) begin
              r_instr <= w_rdata;
              r_valid <= 1'b1;
            end
          end else if (flush) begin
            r_discard <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (flush || w_accept) begin
            r_valid <= 1'b0;
          end
        end
        ST_HALT, ST_FAULT: begin
          r_read   <= 1'b0;
          r_be     <= 4'h0;
          r_valid  <= 1'b0;
          r_active <= 1'b0;
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign avm_address    = r_addr;
  assign avm_read       = r_read;
  assign avm_byteenable = r_be;
  assign instr_out      = r_instr;
  assign instr_valid    = r_valid;
  assign instr_pc       = r_ipc;
  assign pc_adv         = w_accept && !rst;
  assign active         = r_active;
  assign fault          = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mips_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module : tb_mips_instruction_fetch
// Brief  : Directed table plus hand sequences for the instruction fetch stage.
// Rev    : 1.0
// ============================================================================
module tb_mips_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        waitreq = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        ready = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = 32'h0;
  logic [31:0] pc = 32'h0;

  logic [31:0] avm_address, instr_out, instr_pc;
  logic        avm_read, instr_valid, pc_adv, active, fault;
  logic [3:0]  avm_byteenable;

  logic [31:0] s_avm_address, s_instr_out, s_instr_pc;
  logic        s_avm_read, s_instr_valid, s_pc_adv, s_active, s_fault;
  logic [3:0]  s_avm_byteenable;

  int checks = 0;
  int errors = 0;
  int adv_count = 0;
  int adv_snap;

  always #5 clk = ~clk;

  // Program counter model: explicit load, else count by 4 on pc_adv.
  always @(posedge clk) begin
    if (pc_load) pc <= pc_load_val;
    else if (pc_adv) pc <= pc + 32'd4;
  end

  always @(posedge clk) begin
    if (pc_adv && !rst) adv_count <= adv_count + 1;
  end

  mips_instruction_fetch #(.BYTE_SWAP(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .flush(flush),
    .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(waitreq), .avm_readdata(rdata),
    .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(ready),
    .instr_pc(instr_pc), .pc_adv(pc_adv), .active(active), .fault(fault)
  );

  mips_instruction_fetch #(.BYTE_SWAP(1'b1)) u_dut_swap (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .flush(flush),
    .avm_address(s_avm_address), .avm_read(s_avm_read), .avm_byteenable(s_avm_byteenable),
    .avm_waitrequest(waitreq), .avm_readdata(rdata),
    .instr_out(s_instr_out), .instr_valid(s_instr_valid), .instr_ready(ready),
    .instr_pc(s_instr_pc), .pc_adv(s_pc_adv), .active(s_active), .fault(s_fault)
  );

  typedef struct {
    logic        start;
    logic        waitreq;
    logic        ready;
    logic [31:0] rdata;
    logic        e_read;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_adv;
    logic        e_active;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_hold(input string tag, input logic [31:0] instr, input logic [31:0] ipc);
    chk({tag, " valid"}, {31'h0, instr_valid}, 32'h1);
    chk({tag, " instr"}, instr_out, instr);
    chk({tag, " ipc"}, instr_pc, ipc);
  endtask

  initial begin
    // Zero-wait fetch from reset vector, one accept, second fetch then stall in decode.
    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h3C011234, 1'b0, 32'h0,         4'h0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h3C011234, 1'b1, 32'hBFC00000, 4'hF, 1'b0, 32'h0,         32'hBFC00000, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h3C011234, 1'b0, 32'hBFC00000, 4'h0, 1'b1, 32'h3C011234, 32'hBFC00000, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h3C011234, 1'b0, 32'hBFC00000, 4'h0, 1'b0, 32'h3C011234, 32'hBFC00000, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h3C011234, 1'b1, 32'hBFC00004, 4'hF, 1'b0, 32'h3C011234, 32'hBFC00004, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h3C011234, 1'b0, 32'hBFC00004, 4'h0, 1'b1, 32'h3C011234, 32'hBFC00004, 1'b0, 1'b1};

    rst = 1'b1; pc_load = 1'b1; pc_load_val = 32'hBFC00000;
    tick(); tick();
    #1;
    chk("rst read", {31'h0, avm_read}, 32'h0);
    chk("rst addr", avm_address, 32'h0);
    chk("rst be", {28'h0, avm_byteenable}, 32'h0);
    chk("rst instr", instr_out, 32'h0);
    chk("rst valid", {31'h0, instr_valid}, 32'h0);
    chk("rst ipc", instr_pc, 32'h0);
    chk("rst adv", {31'h0, pc_adv}, 32'h0);
    chk("rst active", {31'h0, active}, 32'h0);
    chk("rst fault", {31'h0, fault}, 32'h0);
    rst = 1'b0; pc_load = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      start = vecs[i].start; waitreq = vecs[i].waitreq;
      ready = vecs[i].ready; rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d read", i), {31'h0, avm_read}, {31'h0, vecs[i].e_read});
      chk($sformatf("v%0d addr", i), avm_address, vecs[i].e_addr);
      chk($sformatf("v%0d be", i), {28'h0, avm_byteenable}, {28'h0, vecs[i].e_be});
      chk($sformatf("v%0d valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].e_valid});
      chk($sformatf("v%0d instr", i), instr_out, vecs[i].e_instr);
      chk($sformatf("v%0d ipc", i), instr_pc, vecs[i].e_ipc);
      chk($sformatf("v%0d adv", i), {31'h0, pc_adv}, {31'h0, vecs[i].e_adv});
      chk($sformatf("v%0d active", i), {31'h0, active}, {31'h0, vecs[i].e_active});
    end
    chk("t1 adv count", adv_count, 1);

    // Decode not ready for five cycles: held word stays put.
    for (int i = 0; i < 5; i++) begin
      tick(); ready = 1'b0; #1;
      chk_hold("t3", 32'h3C011234, 32'hBFC00004);
      chk("t3 read", {31'h0, avm_read}, 32'h0);
      chk("t3 adv", {31'h0, pc_adv}, 32'h0);
    end
    tick(); ready = 1'b1; #1;
    chk("t3 adv release", {31'h0, pc_adv}, 32'h1);
    tick(); ready = 1'b0; waitreq = 1'b1; #1;
    chk("t3 valid drop", {31'h0, instr_valid}, 32'h0);
    chk("t3 pc model", pc, 32'hBFC00008);

    // Three stall cycles: address and strobes stable for four cycles.
    adv_snap = adv_count;
    for (int i = 0; i < 3; i++) begin
      tick(); waitreq = 1'b1; #1;
      chk("t2 read", {31'h0, avm_read}, 32'h1);
      chk("t2 addr", avm_address, 32'hBFC00008);
      chk("t2 be", {28'h0, avm_byteenable}, 32'hF);
    end
    tick(); waitreq = 1'b0; rdata = 32'h8C220000; #1;
    chk("t2 read last", {31'h0, avm_read}, 32'h1);
    chk("t2 addr last", avm_address, 32'hBFC00008);
    tick(); ready = 1'b1; waitreq = 1'b1; rdata = 32'hDEADBEEF; #1;
    chk_hold("t2", 32'h8C220000, 32'hBFC00008);
    chk("t2 adv", {31'h0, pc_adv}, 32'h1);
    chk("t2 read off", {31'h0, avm_read}, 32'h0);
    tick(); ready = 1'b0; #1;
    chk("t2 valid drop", {31'h0, instr_valid}, 32'h0);
    chk("t2 adv count", adv_count - adv_snap, 1);

    // Flush during a stalled read: redirect to BFC00100, stale word dropped.
    adv_snap = adv_count;
    tick(); waitreq = 1'b1; flush = 1'b1; pc_load = 1'b1; pc_load_val = 32'hBFC00100; #1;
    chk("t4 read", {31'h0, avm_read}, 32'h1);
    chk("t4 addr", avm_address, 32'hBFC0000C);
    tick(); flush = 1'b0; pc_load = 1'b0; #1;
    chk("t4 addr stable", avm_address, 32'hBFC0000C);
    chk("t4 read stable", {31'h0, avm_read}, 32'h1);
    tick(); waitreq = 1'b0; #1;
    chk("t4 addr done", avm_address, 32'hBFC0000C);
    tick(); waitreq = 1'b1; ready = 1'b1; #1;
    chk("t4 dropped", {31'h0, instr_valid}, 32'h0);
    chk("t4 no adv", {31'h0, pc_adv}, 32'h0);
    chk("t4 read idle", {31'h0, avm_read}, 32'h0);
    tick(); waitreq = 1'b0; rdata = 32'h24030005; #1;
    chk("t4 new read", {31'h0, avm_read}, 32'h1);
    chk("t4 new addr", avm_address, 32'hBFC00100);
    tick(); ready = 1'b1; #1;
    chk_hold("t4", 32'h24030005, 32'hBFC00100);
    chk("t4 adv", {31'h0, pc_adv}, 32'h1);
    tick(); ready = 1'b0; #1;
    chk("t4 adv count", adv_count - adv_snap, 1);

    // Flush coincident with completion drops the word; refetch same pc.
    tick(); waitreq = 1'b0; flush = 1'b1; rdata = 32'h11112222; #1;
    chk("tc addr", avm_address, 32'hBFC00104);
    tick(); flush = 1'b0; #1;
    chk("tc dropped", {31'h0, instr_valid}, 32'h0);
    tick(); #1;
    chk("tc refetch", {31'h0, avm_read}, 32'h1);
    chk("tc refetch addr", avm_address, 32'hBFC00104);
    // Flush beats a ready decode; redirect to the halt address.
    adv_snap = adv_count;
    tick(); ready = 1'b1; flush = 1'b1; pc_load = 1'b1; pc_load_val = 32'h0; #1;
    chk_hold("tf", 32'h11112222, 32'hBFC00104);
    chk("tf no adv", {31'h0, pc_adv}, 32'h0);
    tick(); flush = 1'b0; pc_load = 1'b0; ready = 1'b0; #1;
    chk("tf valid", {31'h0, instr_valid}, 32'h0);
    chk("tf adv count", adv_count - adv_snap, 0);

    // Halt on pc==0.
    for (int i = 0; i < 3; i++) begin
      tick(); ready = 1'b1; #1;
      chk("t5 halt active", {31'h0, active}, 32'h0);
      chk("t5 halt read", {31'h0, avm_read}, 32'h0);
      chk("t5 halt be", {28'h0, avm_byteenable}, 32'h0);
      chk("t5 halt valid", {31'h0, instr_valid}, 32'h0);
      chk("t5 halt fault", {31'h0, fault}, 32'h0);
    end

    // Misaligned pc faults.
    tick(); rst = 1'b1; ready = 1'b0; pc_load = 1'b1; pc_load_val = 32'hBFC00002; start = 1'b0;
    tick(); rst = 1'b0; pc_load = 1'b0; start = 1'b1; #1;
    chk("t5 pre fault", {31'h0, fault}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); start = 1'b0; #1;
      chk("t5 fault", {31'h0, fault}, 32'h1);
      chk("t5 fault active", {31'h0, active}, 32'h0);
      chk("t5 fault read", {31'h0, avm_read}, 32'h0);
    end

    // Reset mid-REQ.
    tick(); rst = 1'b1; pc_load = 1'b1; pc_load_val = 32'hBFC00000;
    tick(); rst = 1'b0; pc_load = 1'b0; start = 1'b1; waitreq = 1'b1; #1;
    tick(); start = 1'b0; #1;
    chk("t6 in req", {31'h0, avm_read}, 32'h1);
    chk("t6 fault cleared", {31'h0, fault}, 32'h0);
    tick(); rst = 1'b1; #1;
    tick(); #1;
    chk("t6 read", {31'h0, avm_read}, 32'h0);
    chk("t6 addr", avm_address, 32'h0);
    chk("t6 be", {28'h0, avm_byteenable}, 32'h0);
    chk("t6 valid", {31'h0, instr_valid}, 32'h0);
    chk("t6 ipc", instr_pc, 32'h0);
    chk("t6 active", {31'h0, active}, 32'h0);

    // Byte swap variant.
    tick(); rst = 1'b0; start = 1'b1; waitreq = 1'b0; rdata = 32'h11223344; #1;
    tick(); start = 1'b0; #1;
    chk("t6 swap read", {31'h0, s_avm_read}, 32'h1);
    tick(); #1;
    chk("t6 swap instr", s_instr_out, 32'h44332211);
    chk("t6 swap valid", {31'h0, s_instr_valid}, 32'h1);
    chk("t6 plain instr", instr_out, 32'h11223344);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
